// File: rtl/noc_pkt_pkg.sv
// Shared packet helpers for the NoC test environment.
// Holds default packet geometry, the lane FSM state type, field extraction
// functions (destination, payload) and a saturating adder used by all counters.
package noc_pkt_pkg;

    localparam int unsigned DefDwidth = 8;
    localparam int unsigned DefPwidth = 47;
    localparam int unsigned DefAwidth = 4;

    // Widest packet the helpers accept; narrower packets are zero-extended.
    localparam int unsigned MaxPwidth = 256;

    typedef logic [MaxPwidth-1:0] pkt_bus_t;

    typedef enum logic [0:0] {StReady, StWait} lane_state_e;

    // Destination field lives in the top AWIDTH bits of the packet.
    function automatic logic [63:0] get_dest(input pkt_bus_t pkt, input int unsigned pwidth,
                                             input int unsigned awidth);
        pkt_bus_t sh;
        sh = pkt >> (pwidth - awidth);
        return sh[63:0] & ((64'd1 << awidth) - 64'd1);
    endfunction

    // Payload occupies the low DWIDTH bits of the packet.
    function automatic logic [63:0] get_payload(input pkt_bus_t pkt, input int unsigned dwidth);
        return pkt[63:0] & ((64'd1 << dwidth) - 64'd1);
    endfunction

    // a + inc, clamped to 2^width-1.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] inc,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] max;
        max = (width >= 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << width) - 65'd1);
        sum = {1'b0, a} + {1'b0, inc};
        return (sum > max) ? max[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/data_bucket_multi_if.sv
// Packet handshake bundle for data_bucket_multi.
//   in_valid  : per-channel packet valid (master -> slave)
//   in_ready  : per-channel ready (slave -> master)
//   in_packet : channel i at bits [i*PWIDTH +: PWIDTH] (master -> slave)
interface data_bucket_multi_if #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned PWIDTH = 47
);
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_ready;
    logic [NCH*PWIDTH-1:0] in_packet;

    modport master (output in_valid, output in_packet, input in_ready);
    modport slave  (input in_valid, input in_packet, output in_ready);
endinterface

// File: rtl/data_bucket_lane.sv
// One channel of the packet bucket: READY/WAIT FSM with a wait counter that
// models consumer latency, plus last payload and a saturating packet count.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : zero pkt_count (handshake state untouched)
//   in_valid_i    : packet valid; in_ready_o : registered ready
//   in_packet_i   : packet, sampled only on accept
//   last_data_o   : payload of last accepted packet
//   pkt_count_o   : accepted packets, saturating
//   accept_o      : accept this cycle; mismatch_o : accept with foreign dest
module data_bucket_lane
    import noc_pkt_pkg::*;
#(
    parameter int unsigned DWIDTH  = DefDwidth,
    parameter int unsigned PWIDTH  = DefPwidth,
    parameter int unsigned AWIDTH  = DefAwidth,
    parameter int unsigned MY_ADDR = 0,
    parameter int unsigned BL      = 0,
    parameter int unsigned CWIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PWIDTH-1:0] in_packet_i,
    output logic [DWIDTH-1:0] last_data_o,
    output logic [CWIDTH-1:0] pkt_count_o,
    output logic              accept_o,
    output logic              mismatch_o
);
    localparam int unsigned CntW = (BL > 0) ? $clog2(BL + 1) : 1;

    lane_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [DWIDTH-1:0] last_data_q, last_data_d;
    logic [CWIDTH-1:0] pkt_count_q, pkt_count_d;

    pkt_bus_t    pkt_ext;
    logic [63:0] dest;
    logic        accept;

    assign pkt_ext = pkt_bus_t'(in_packet_i);
    assign dest    = get_dest(pkt_ext, PWIDTH, AWIDTH);
    assign accept  = in_valid_i & ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        last_data_d = accept ? DWIDTH'(get_payload(pkt_ext, DWIDTH)) : last_data_q;
        pkt_count_d = CWIDTH'(sat_add(clear_i ? 64'd0 : 64'(pkt_count_q), 64'(accept), CWIDTH));
        unique case (state_q)
            StReady: begin
                ready_d = 1'b1;
                if (accept && (BL > 0)) begin
                    state_d = StWait;
                    cnt_d   = CntW'(BL);
                    ready_d = 1'b0;
                end
            end
            StWait: begin
                // Ready is registered, so it rises the cycle after the count hits 1.
                if (cnt_q <= CntW'(1)) begin
                    state_d = StReady;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StReady;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StReady;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            last_data_q <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            last_data_q <= last_data_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign last_data_o = last_data_q;
    assign pkt_count_o = pkt_count_q;
    assign accept_o    = accept;
    assign mismatch_o  = accept && (dest != 64'(MY_ADDR));

endmodule

// File: rtl/data_bucket_multi.sv
// Multi-channel packet sink for NoC tests: NCH lanes, each with programmable
// bucket latency BL, plus aggregate total/misroute counters and a sticky
// misroute flag. All counters saturate at 2^CWIDTH-1.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : zero counters and err_flag; handshake state untouched
//   bus         : slave side of the valid/ready/packet bundle
//   last_data   : per-lane last accepted payload
//   pkt_count   : per-lane accepted count
//   total_count : accepts across all lanes
//   err_count   : accepts with dest != MY_ADDR; err_flag : sticky misroute
// Define DATA_BUCKET_TRACE_EN to print a line per accept (simulation only).
module data_bucket_multi
    import noc_pkt_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DWIDTH  = DefDwidth,
    parameter int unsigned PWIDTH  = DefPwidth,
    parameter int unsigned AWIDTH  = DefAwidth,
    parameter int unsigned MY_ADDR = 0,
    parameter int unsigned BL      = 0,
    parameter int unsigned CWIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    data_bucket_multi_if.slave     bus,
    output logic [NCH*DWIDTH-1:0]  last_data,
    output logic [NCH*CWIDTH-1:0]  pkt_count,
    output logic [CWIDTH-1:0]      total_count,
    output logic [CWIDTH-1:0]      err_count,
    output logic                   err_flag
);
    localparam int unsigned SumW = $clog2(NCH + 1);

    logic [NCH-1:0]    accept;
    logic [NCH-1:0]    mismatch;
    logic [SumW-1:0]   n_acc, n_err;
    logic [CWIDTH-1:0] total_count_q, total_count_d;
    logic [CWIDTH-1:0] err_count_q, err_count_d;
    logic              err_flag_q, err_flag_d;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        data_bucket_lane #(
            .DWIDTH  (DWIDTH),
            .PWIDTH  (PWIDTH),
            .AWIDTH  (AWIDTH),
            .MY_ADDR (MY_ADDR),
            .BL      (BL),
            .CWIDTH  (CWIDTH)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .clear_i     (clear),
            .in_valid_i  (bus.in_valid[i]),
            .in_ready_o  (bus.in_ready[i]),
            .in_packet_i (bus.in_packet[i*PWIDTH +: PWIDTH]),
            .last_data_o (last_data[i*DWIDTH +: DWIDTH]),
            .pkt_count_o (pkt_count[i*CWIDTH +: CWIDTH]),
            .accept_o    (accept[i]),
            .mismatch_o  (mismatch[i])
        );
    end

    always_comb begin
        n_acc = '0;
        n_err = '0;
        for (int i = 0; i < NCH; i++) begin
            n_acc = n_acc + SumW'(accept[i]);
            n_err = n_err + SumW'(mismatch[i]);
        end
        // On clear, this cycle's increments apply on top of zero.
        total_count_d = CWIDTH'(sat_add(clear ? 64'd0 : 64'(total_count_q), 64'(n_acc), CWIDTH));
        err_count_d   = CWIDTH'(sat_add(clear ? 64'd0 : 64'(err_count_q), 64'(n_err), CWIDTH));
        err_flag_d    = (err_flag_q & ~clear) | (|mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_count_q <= '0;
            err_count_q   <= '0;
            err_flag_q    <= 1'b0;
        end else begin
            total_count_q <= total_count_d;
            err_count_q   <= err_count_d;
            err_flag_q    <= err_flag_d;
        end
    end

    assign total_count = total_count_q;
    assign err_count   = err_count_q;
    assign err_flag    = err_flag_q;

`ifdef DATA_BUCKET_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                if (accept[i]) begin
                    $display("%m lane %0d data %0h dest %0h t=%0t", i,
                             get_payload(pkt_bus_t'(bus.in_packet[i*PWIDTH +: PWIDTH]), DWIDTH),
                             get_dest(pkt_bus_t'(bus.in_packet[i*PWIDTH +: PWIDTH]),
                                      PWIDTH, AWIDTH), $realtime);
                    if (mismatch[i]) begin
                        $display("%m ERROR lane %0d misrouted packet (expected dest %0h) t=%0t",
                                 i, MY_ADDR, $realtime);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_bucket_multi.sv
// Directed bench for data_bucket_multi. Three instances share clk/rst:
//   dut_a : BL=0, CWIDTH=16  (streaming, misroute, simultaneous lanes, clear)
//   dut_b : BL=3, CWIDTH=16  (backpressure, reset mid-WAIT)
//   dut_c : BL=0, CWIDTH=4   (saturation, clear coincident with accept)
module tb_data_bucket_multi;
    localparam int unsigned Nch = 4;
    localparam int unsigned Pw  = 47;

    logic clk = 1'b0;
    logic rst;
    logic clear_a, clear_b, clear_c;

    always #5 clk = ~clk;

    data_bucket_multi_if #(.NCH(Nch), .PWIDTH(Pw)) if_a ();
    data_bucket_multi_if #(.NCH(Nch), .PWIDTH(Pw)) if_b ();
    data_bucket_multi_if #(.NCH(Nch), .PWIDTH(Pw)) if_c ();

    logic [Nch*8-1:0]  a_last, b_last, c_last;
    logic [Nch*16-1:0] a_pkt, b_pkt;
    logic [Nch*4-1:0]  c_pkt;
    logic [15:0]       a_tot, a_err, b_tot, b_err;
    logic [3:0]        c_tot, c_err;
    logic              a_flag, b_flag, c_flag;

    data_bucket_multi #(.NCH(Nch), .BL(0), .CWIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .clear(clear_a), .bus(if_a.slave), .last_data(a_last),
        .pkt_count(a_pkt), .total_count(a_tot), .err_count(a_err), .err_flag(a_flag)
    );
    data_bucket_multi #(.NCH(Nch), .BL(3), .CWIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .clear(clear_b), .bus(if_b.slave), .last_data(b_last),
        .pkt_count(b_pkt), .total_count(b_tot), .err_count(b_err), .err_flag(b_flag)
    );
    data_bucket_multi #(.NCH(Nch), .BL(0), .CWIDTH(4)) dut_c (
        .clk(clk), .rst(rst), .clear(clear_c), .bus(if_c.slave), .last_data(c_last),
        .pkt_count(c_pkt), .total_count(c_tot), .err_count(c_err), .err_flag(c_flag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [Pw-1:0] mk_pkt(input logic [3:0] dest, input logic [7:0] data);
        return {dest, 35'h0, data};
    endfunction

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
        if_a.in_valid = '0; if_b.in_valid = '0; if_c.in_valid = '0;
        if_a.in_packet = '0; if_b.in_packet = '0; if_c.in_packet = '0;

        // Reset / idle
        repeat (3) tick();
        check_eq("rst_ready_a", 64'(if_a.in_ready), 64'h0);
        check_eq("rst_ready_b", 64'(if_b.in_ready), 64'h0);
        check_eq("rst_last_a", 64'(a_last), 64'h0);
        check_eq("rst_pkt_a", 64'(a_pkt), 64'h0);
        check_eq("rst_tot_a", 64'(a_tot), 64'h0);
        check_eq("rst_err_a", 64'(a_err), 64'h0);
        check_eq("rst_flag_a", 64'(a_flag), 64'h0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_ready_a", 64'(if_a.in_ready), 64'hf);
        check_eq("post_rst_ready_b", 64'(if_b.in_ready), 64'hf);

        // BL=0 streaming on lane 0 of dut_a
        if_a.in_valid[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if_a.in_packet[0 +: Pw] = mk_pkt(4'd0, 8'(k));
            tick();
        end
        if_a.in_valid[0] = 1'b0;
        check_eq("stream_pkt0", 64'(a_pkt[0 +: 16]), 64'd10);
        check_eq("stream_tot", 64'(a_tot), 64'd10);
        check_eq("stream_last0", 64'(a_last[0 +: 8]), 64'd10);
        check_eq("stream_flag", 64'(a_flag), 64'd0);
        tick();
        check_eq("stream_hold_pkt0", 64'(a_pkt[0 +: 16]), 64'd10);

        // Misroute on lane 1 of dut_a
        if_a.in_valid[1] = 1'b1;
        if_a.in_packet[1*Pw +: Pw] = mk_pkt(4'd1, 8'h77);
        tick();
        if_a.in_valid[1] = 1'b0;
        check_eq("mis_pkt1", 64'(a_pkt[16 +: 16]), 64'd1);
        check_eq("mis_last1", 64'(a_last[8 +: 8]), 64'h77);
        check_eq("mis_err", 64'(a_err), 64'd1);
        check_eq("mis_flag", 64'(a_flag), 64'd1);
        check_eq("mis_tot", 64'(a_tot), 64'd11);
        repeat (3) tick();
        check_eq("mis_flag_sticky", 64'(a_flag), 64'd1);

        // All four lanes of dut_a in one cycle
        for (int i = 0; i < Nch; i++) begin
            if_a.in_packet[i*Pw +: Pw] = mk_pkt(4'd0, 8'(8'hA0 + i));
        end
        if_a.in_valid = 4'hf;
        tick();
        if_a.in_valid = 4'h0;
        check_eq("simul_tot", 64'(a_tot), 64'd15);
        check_eq("simul_pkt1", 64'(a_pkt[16 +: 16]), 64'd2);
        check_eq("simul_pkt3", 64'(a_pkt[48 +: 16]), 64'd1);
        check_eq("simul_last3", 64'(a_last[24 +: 8]), 64'hA3);
        check_eq("simul_err", 64'(a_err), 64'd1);

        // Clear without accept
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        check_eq("clr_tot", 64'(a_tot), 64'd0);
        check_eq("clr_err", 64'(a_err), 64'd0);
        check_eq("clr_flag", 64'(a_flag), 64'd0);
        check_eq("clr_pkt0", 64'(a_pkt[0 +: 16]), 64'd0);
        check_eq("clr_ready", 64'(if_a.in_ready), 64'hf);

        // BL=3 backpressure on lane 2 of dut_b
        if_b.in_valid[2] = 1'b1;
        if_b.in_packet[2*Pw +: Pw] = mk_pkt(4'd0, 8'h55);
        for (int i = 0; i < 20; i++) begin
            check_eq($sformatf("bp_ready2_c%0d", i), 64'(if_b.in_ready[2]), 64'((i % 4) == 0));
            tick();
        end
        if_b.in_valid[2] = 1'b0;
        check_eq("bp_pkt2", 64'(b_pkt[32 +: 16]), 64'd5);
        check_eq("bp_tot", 64'(b_tot), 64'd5);
        check_eq("bp_last2", 64'(b_last[16 +: 8]), 64'h55);

        // Saturation on dut_c (CWIDTH=4), all misrouted
        if_c.in_valid[3] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if_c.in_packet[3*Pw +: Pw] = mk_pkt(4'd5, 8'(k));
            tick();
        end
        check_eq("sat_pkt3", 64'(c_pkt[12 +: 4]), 64'd15);
        check_eq("sat_tot", 64'(c_tot), 64'd15);
        check_eq("sat_err", 64'(c_err), 64'd15);
        check_eq("sat_flag", 64'(c_flag), 64'd1);
        check_eq("sat_last3", 64'(c_last[24 +: 8]), 64'd20);

        // Clear coincident with a well-routed accept
        clear_c = 1'b1;
        if_c.in_packet[3*Pw +: Pw] = mk_pkt(4'd0, 8'h33);
        tick();
        clear_c = 1'b0;
        if_c.in_valid[3] = 1'b0;
        check_eq("clracc_pkt3", 64'(c_pkt[12 +: 4]), 64'd1);
        check_eq("clracc_tot", 64'(c_tot), 64'd1);
        check_eq("clracc_err", 64'(c_err), 64'd0);
        check_eq("clracc_flag", 64'(c_flag), 64'd0);
        check_eq("clracc_last3", 64'(c_last[24 +: 8]), 64'h33);

        // Reset while lane 0 of dut_b is waiting
        if_b.in_valid[0] = 1'b1;
        if_b.in_packet[0 +: Pw] = mk_pkt(4'd0, 8'h11);
        tick();
        if_b.in_valid[0] = 1'b0;
        check_eq("wait_ready0", 64'(if_b.in_ready[0]), 64'd0);
        check_eq("wait_pkt0", 64'(b_pkt[0 +: 16]), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_ready", 64'(if_b.in_ready), 64'h0);
        check_eq("midrst_pkt0", 64'(b_pkt[0 +: 16]), 64'd0);
        check_eq("midrst_tot", 64'(b_tot), 64'd0);
        tick();
        check_eq("midrst_ready_back", 64'(if_b.in_ready), 64'hf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
